// File: rtl/csr_pkg.sv
// Shared CSR definitions: addresses, mstatus field positions, interrupt causes
// and the trap/MRET sequencer state type.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;

    // mstatus bit positions; MPP occupies [MSTATUS_MPP+1:MSTATUS_MPP]
    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;
    localparam int unsigned MSTATUS_MPP  = 11;

    localparam int unsigned IRQ_MEI = 11;
    localparam int unsigned IRQ_MSI = 3;
    localparam int unsigned IRQ_MTI = 7;

    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_T_EPC,
        S_T_CAUSE,
        S_T_TVAL,
        S_T_STATUS,
        S_M_STATUS,
        S_REDIR
    } trap_state_t;

endpackage

// File: rtl/csr_irq_sel.sv
// Machine interrupt pending check and cause priority encoder (MEI > MSI > MTI).
module csr_irq_sel
    import csr_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] mstatus,
    input  logic [XLEN-1:0] mie,
    input  logic [XLEN-1:0] mip,
    output logic            irq,
    output logic [4:0]      code
);

    logic mei, msi, mti;
    logic unused_bits;

    // Only the three machine-level sources and the global enable matter here
    assign unused_bits = &{1'b0, mstatus, mie, mip};

    // Pending/enabled sources, gated by mstatus.MIE, and highest-priority cause
    always_comb begin
        mei  = mie[IRQ_MEI] & mip[IRQ_MEI];
        msi  = mie[IRQ_MSI] & mip[IRQ_MSI];
        mti  = mie[IRQ_MTI] & mip[IRQ_MTI];
        irq  = mstatus[MSTATUS_MIE] & (mei | msi | mti);
        if (mei)
            code = 5'(IRQ_MEI);
        else if (msi)
            code = 5'(IRQ_MSI);
        else
            code = 5'(IRQ_MTI);
    end

endmodule

// File: rtl/csr_trap_ctrl.sv
// Trap-entry / MRET sequencer sharing the CSR file's single write port with
// W-stage CSR instructions; stalls and redirects the pipeline.
module csr_trap_ctrl
    import csr_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exc_valid,
    output logic              exc_ready,
    input  logic [4:0]        exc_code,
    input  logic [XLEN-1:0]   exc_pc,
    input  logic [XLEN-1:0]   exc_tval,
    input  logic              mret_valid,
    input  logic              wb_csr_valid,
    output logic              wb_csr_ready,
    input  logic [CSR_AW-1:0] wb_csr_wa,
    input  logic [XLEN-1:0]   wb_csr_wd,
    input  logic [XLEN-1:0]   mstatus_i,
    input  logic [XLEN-1:0]   mie_i,
    input  logic [XLEN-1:0]   mip_i,
    input  logic [XLEN-1:0]   mtvec_i,
    input  logic [XLEN-1:0]   mepc_i,
    output logic              csr_valid,
    output logic [CSR_AW-1:0] csr_wa,
    output logic [XLEN-1:0]   csr_wd,
    output logic              stall,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc
);

    trap_state_t     state;
    logic [4:0]      lat_code;
    logic [XLEN-1:0] lat_pc;
    logic [XLEN-1:0] lat_tval;
    logic [XLEN-1:0] lat_tgt;
    logic            lat_intr;
    logic            lat_mret;

    logic            irq;
    logic [4:0]      irq_code;
    logic            accept;
    logic [XLEN-1:0] mtvec_base;
    logic [XLEN-1:0] trap_tgt;
    logic [XLEN-1:0] st_trap;
    logic [XLEN-1:0] st_mret;

    csr_irq_sel #(.XLEN(XLEN)) u_irq_sel (
        .mstatus (mstatus_i),
        .mie     (mie_i),
        .mip     (mip_i),
        .irq     (irq),
        .code    (irq_code)
    );

    // Handshake and stall: IDLE owns nothing, so the W stage gets the port
    always_comb begin
        accept       = reset && (state == S_IDLE) && (exc_valid || irq || mret_valid);
        exc_ready    = (state == S_IDLE);
        wb_csr_ready = reset && (state == S_IDLE);
        stall        = (state != S_IDLE) || accept;
    end

    // mstatus update values and trap target, all from live CSR reads so a
    // W-stage write granted in the accept cycle is already visible here
    always_comb begin
        st_trap                      = mstatus_i;
        st_trap[MSTATUS_MPIE]        = mstatus_i[MSTATUS_MIE];
        st_trap[MSTATUS_MIE]         = 1'b0;
        st_trap[MSTATUS_MPP +: 2]    = 2'b11;
        st_mret                      = mstatus_i;
        st_mret[MSTATUS_MIE]         = mstatus_i[MSTATUS_MPIE];
        st_mret[MSTATUS_MPIE]        = 1'b1;
        st_mret[MSTATUS_MPP +: 2]    = 2'b11;
        mtvec_base                   = {mtvec_i[XLEN-1:2], 2'b00};
        if ((mtvec_i[1:0] == MTVEC_MODE_VECTORED) && lat_intr)
            trap_tgt = mtvec_base + (XLEN'(lat_code) << 2);
        else
            trap_tgt = mtvec_base;
    end

    // Write-port mux and redirect, selected by sequencer state
    always_comb begin
        csr_valid      = 1'b0;
        csr_wa         = '0;
        csr_wd         = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        unique case (state)
            S_IDLE: begin
                if (reset) begin
                    csr_valid = wb_csr_valid;
                    csr_wa    = wb_csr_wa;
                    csr_wd    = wb_csr_wd;
                end
            end
            S_T_EPC: begin
                csr_valid = 1'b1;
                csr_wa    = CSR_AW'(CSR_MEPC);
                csr_wd    = {lat_pc[XLEN-1:2], 2'b00};
            end
            S_T_CAUSE: begin
                csr_valid       = 1'b1;
                csr_wa          = CSR_AW'(CSR_MCAUSE);
                csr_wd[XLEN-1]  = lat_intr;
                csr_wd[4:0]     = lat_code;
            end
            S_T_TVAL: begin
                csr_valid = 1'b1;
                csr_wa    = CSR_AW'(CSR_MTVAL);
                csr_wd    = lat_tval;
            end
            S_T_STATUS: begin
                csr_valid = 1'b1;
                csr_wa    = CSR_AW'(CSR_MSTATUS);
                csr_wd    = st_trap;
            end
            S_M_STATUS: begin
                csr_valid = 1'b1;
                csr_wa    = CSR_AW'(CSR_MSTATUS);
                csr_wd    = st_mret;
            end
            S_REDIR: begin
                redirect_valid = 1'b1;
                redirect_pc    = lat_mret ? lat_tgt : trap_tgt;
            end
            default: ;
        endcase
    end

    // Sequencer: accept one event in IDLE, then step one CSR write per cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            lat_code <= '0;
            lat_pc   <= '0;
            lat_tval <= '0;
            lat_tgt  <= '0;
            lat_intr <= 1'b0;
            lat_mret <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (exc_valid || irq) begin
                        lat_pc   <= exc_pc;
                        lat_intr <= !exc_valid;
                        lat_code <= exc_valid ? exc_code : irq_code;
                        lat_tval <= exc_valid ? exc_tval : '0;
                        lat_mret <= 1'b0;
                        state    <= S_T_EPC;
                    end else if (mret_valid) begin
                        lat_tgt  <= mepc_i;
                        lat_mret <= 1'b1;
                        state    <= S_M_STATUS;
                    end
                end
                S_T_EPC:    state <= S_T_CAUSE;
                S_T_CAUSE:  state <= S_T_TVAL;
                S_T_TVAL:   state <= S_T_STATUS;
                S_T_STATUS: state <= S_REDIR;
                S_M_STATUS: state <= S_REDIR;
                S_REDIR:    state <= S_IDLE;
                default:    state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Self-checking bench for csr_trap_ctrl: directed scenarios plus random
// traffic against a transaction-level model of the CSR file and trap rules.
module tb_csr_trap_ctrl;
    import csr_pkg::*;

    localparam int XLEN   = 64;
    localparam int CSR_AW = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic              exc_valid;
    logic              exc_ready;
    logic [4:0]        exc_code;
    logic [XLEN-1:0]   exc_pc;
    logic [XLEN-1:0]   exc_tval;
    logic              mret_valid;
    logic              wb_csr_valid;
    logic              wb_csr_ready;
    logic [CSR_AW-1:0] wb_csr_wa;
    logic [XLEN-1:0]   wb_csr_wd;
    logic [XLEN-1:0]   mstatus_i, mie_i, mip_i, mtvec_i, mepc_i;
    logic              csr_valid;
    logic [CSR_AW-1:0] csr_wa;
    logic [XLEN-1:0]   csr_wd;
    logic              stall;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;

    always #5 clk = ~clk;

    csr_trap_ctrl #(.XLEN(XLEN), .CSR_AW(CSR_AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .exc_valid      (exc_valid),
        .exc_ready      (exc_ready),
        .exc_code       (exc_code),
        .exc_pc         (exc_pc),
        .exc_tval       (exc_tval),
        .mret_valid     (mret_valid),
        .wb_csr_valid   (wb_csr_valid),
        .wb_csr_ready   (wb_csr_ready),
        .wb_csr_wa      (wb_csr_wa),
        .wb_csr_wd      (wb_csr_wd),
        .mstatus_i      (mstatus_i),
        .mie_i          (mie_i),
        .mip_i          (mip_i),
        .mtvec_i        (mtvec_i),
        .mepc_i         (mepc_i),
        .csr_valid      (csr_valid),
        .csr_wa         (csr_wa),
        .csr_wd         (csr_wd),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    typedef struct {
        logic        wv;
        logic [11:0] wa;
        logic [63:0] wd;
        logic        rv;
        logic [63:0] rpc;
    } exp_t;

    exp_t        sched[$];
    logic [63:0] csrm  [logic [11:0]];
    logic [63:0] obs_w [logic [11:0]];
    logic [63:0] last_redir;
    logic [11:0] addrs [7];
    int          cyc = 0;
    int          acc_cyc = 0;
    int          redir_cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [63:0] rd(input logic [11:0] a);
        return csrm.exists(a) ? csrm[a] : 64'd0;
    endfunction

    function automatic void push_w(input logic [11:0] a, input logic [63:0] d);
        exp_t e;
        e.wv = 1'b1; e.wa = a; e.wd = d; e.rv = 1'b0; e.rpc = '0;
        sched.push_back(e);
    endfunction

    function automatic void push_r(input logic [63:0] pc);
        exp_t e;
        e.wv = 1'b0; e.wa = '0; e.wd = '0; e.rv = 1'b1; e.rpc = pc;
        sched.push_back(e);
    endfunction

    task automatic idle_in();
        exc_valid    = 1'b0;
        mret_valid   = 1'b0;
        wb_csr_valid = 1'b0;
    endtask

    // Called at posedge+1 with request inputs already set; checks mid-cycle
    task automatic step();
        exp_t        e;
        logic [63:0] pend, mst, mtv, old_mepc, tgt;
        logic        take_irq, acc, is_int;
        logic [4:0]  icode, code;
        mstatus_i = rd(CSR_MSTATUS);
        mie_i     = rd(CSR_MIE);
        mip_i     = rd(CSR_MIP);
        mtvec_i   = rd(CSR_MTVEC);
        mepc_i    = rd(CSR_MEPC);
        #3;
        cyc++;
        if (csr_valid) obs_w[csr_wa] = csr_wd;
        if (redirect_valid) begin
            last_redir = redirect_pc;
            redir_cyc  = cyc;
        end
        if (sched.size() > 0) begin
            e = sched.pop_front();
            check_eq("exc_ready_busy", exc_ready, 1'b0);
            check_eq("wb_ready_busy", wb_csr_ready, 1'b0);
            check_eq("stall_busy", stall, 1'b1);
            check_eq("csr_valid_busy", csr_valid, e.wv);
            check_eq("redir_valid_busy", redirect_valid, e.rv);
            if (e.wv) begin
                check_eq("csr_wa_busy", csr_wa, e.wa);
                check_eq("csr_wd_busy", csr_wd, e.wd);
                csrm[e.wa] = e.wd;
            end
            if (e.rv) check_eq("redir_pc", redirect_pc, e.rpc);
        end else begin
            pend     = rd(CSR_MIE) & rd(CSR_MIP) & 64'h888;
            mst      = rd(CSR_MSTATUS);
            take_irq = mst[3] && (pend != 64'd0);
            icode    = pend[11] ? 5'd11 : (pend[3] ? 5'd3 : 5'd7);
            acc      = exc_valid || take_irq || mret_valid;
            old_mepc = rd(CSR_MEPC);
            check_eq("exc_ready_idle", exc_ready, 1'b1);
            check_eq("wb_ready_idle", wb_csr_ready, 1'b1);
            check_eq("stall_idle", stall, acc);
            check_eq("redir_valid_idle", redirect_valid, 1'b0);
            check_eq("csr_valid_idle", csr_valid, wb_csr_valid);
            if (wb_csr_valid) begin
                check_eq("csr_wa_pass", csr_wa, wb_csr_wa);
                check_eq("csr_wd_pass", csr_wd, wb_csr_wd);
                csrm[wb_csr_wa] = wb_csr_wd;
            end
            if (acc) acc_cyc = cyc;
            mst = rd(CSR_MSTATUS);
            mtv = rd(CSR_MTVEC);
            if (exc_valid || take_irq) begin
                is_int = !exc_valid;
                code   = exc_valid ? exc_code : icode;
                push_w(CSR_MEPC, exc_pc & ~64'd3);
                push_w(CSR_MCAUSE, (is_int ? 64'h8000_0000_0000_0000 : 64'd0) | 64'(code));
                push_w(CSR_MTVAL, exc_valid ? exc_tval : 64'd0);
                push_w(CSR_MSTATUS, (mst & ~64'h1888) | (mst[3] ? 64'h80 : 64'h0) | 64'h1800);
                tgt = mtv & ~64'd3;
                if (is_int && mtv[1:0] == 2'd1) tgt = tgt + 64'(code) * 4;
                push_r(tgt);
            end else if (mret_valid) begin
                push_w(CSR_MSTATUS, (mst & ~64'h1888) | (mst[7] ? 64'h8 : 64'h0) | 64'h80 | 64'h1800);
                push_r(old_mepc);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        addrs[0] = CSR_MSTATUS; addrs[1] = CSR_MIE;   addrs[2] = CSR_MIP;
        addrs[3] = CSR_MTVEC;   addrs[4] = CSR_MEPC;  addrs[5] = CSR_MSCRATCH;
        addrs[6] = CSR_MSTATUS;
        reset = 1'b0;
        idle_in();
        exc_code = '0; exc_pc = '0; exc_tval = '0; wb_csr_wa = '0; wb_csr_wd = '0;
        mstatus_i = '0; mie_i = '0; mip_i = '0; mtvec_i = '0; mepc_i = '0;
        repeat (3) @(posedge clk);
        #3;
        check_eq("rst_csr_valid", csr_valid, 1'b0);
        check_eq("rst_redir_valid", redirect_valid, 1'b0);
        check_eq("rst_stall", stall, 1'b0);
        check_eq("rst_exc_ready", exc_ready, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Synchronous exception, direct mtvec
        csrm[CSR_MSTATUS] = 64'h8; csrm[CSR_MTVEC] = 64'h8000_1000;
        csrm[CSR_MIE] = 64'h0; csrm[CSR_MIP] = 64'h0;
        obs_w.delete();
        exc_valid = 1'b1; exc_code = 5'd2; exc_pc = 64'h8000_0106; exc_tval = 64'hDEAD;
        step();
        idle_in();
        repeat (6) step();
        check_eq("exc_mepc", obs_w[CSR_MEPC], 64'h8000_0104);
        check_eq("exc_mcause", obs_w[CSR_MCAUSE], 64'd2);
        check_eq("exc_mtval", obs_w[CSR_MTVAL], 64'hDEAD);
        check_eq("exc_mstatus", obs_w[CSR_MSTATUS], 64'h1880);
        check_eq("exc_redir_pc", last_redir, 64'h8000_1000);
        check_eq("exc_redir_lat", 64'(redir_cyc - acc_cyc), 64'd5);

        // MRET
        csrm[CSR_MEPC] = 64'h8000_0200; csrm[CSR_MSTATUS] = 64'h80;
        obs_w.delete();
        mret_valid = 1'b1;
        step();
        idle_in();
        repeat (3) step();
        check_eq("mret_mstatus", obs_w[CSR_MSTATUS], 64'h1888);
        check_eq("mret_redir_pc", last_redir, 64'h8000_0200);
        check_eq("mret_redir_lat", 64'(redir_cyc - acc_cyc), 64'd2);

        // Interrupt, vectored mtvec, all three sources pending
        csrm[CSR_MIE] = 64'h888; csrm[CSR_MIP] = 64'h888;
        csrm[CSR_MSTATUS] = 64'h8; csrm[CSR_MTVEC] = 64'h8000_1001;
        obs_w.delete();
        repeat (7) step();
        check_eq("irq_mcause", obs_w[CSR_MCAUSE], 64'h8000_0000_0000_000B);
        check_eq("irq_redir_pc", last_redir, 64'h8000_102C);

        // Exception with a same-cycle W-stage write, then a held W request
        csrm[CSR_MSTATUS] = 64'h8; csrm[CSR_MIE] = 64'h0; csrm[CSR_MIP] = 64'h0;
        csrm[CSR_MTVEC] = 64'h8000_1000;
        obs_w.delete();
        exc_valid = 1'b1; exc_code = 5'd5; exc_pc = 64'h8000_0400; exc_tval = 64'h12;
        wb_csr_valid = 1'b1; wb_csr_wa = CSR_MSCRATCH; wb_csr_wd = 64'h55;
        step();
        exc_valid = 1'b0; wb_csr_wd = 64'h66;
        repeat (5) step();
        check_eq("wb_same_cycle", obs_w[CSR_MSCRATCH], 64'h55);
        step();
        idle_in();
        check_eq("wb_held_grant", obs_w[CSR_MSCRATCH], 64'h66);

        // exc and mret together; MIE=0 keeps pending interrupts masked
        csrm[CSR_MSTATUS] = 64'h0; csrm[CSR_MIE] = 64'h888; csrm[CSR_MIP] = 64'h888;
        csrm[CSR_MEPC] = 64'h1234; csrm[CSR_MTVEC] = 64'h8000_2000;
        obs_w.delete();
        exc_valid = 1'b1; mret_valid = 1'b1; exc_code = 5'd1; exc_pc = 64'h9000;
        step();
        idle_in();
        repeat (8) step();
        check_eq("both_mstatus", obs_w[CSR_MSTATUS], 64'h1800);
        check_eq("both_redir_pc", last_redir, 64'h8000_2000);

        // Reset asserted during T_CAUSE
        csrm[CSR_MSTATUS] = 64'h8; csrm[CSR_MIE] = 64'h0; csrm[CSR_MIP] = 64'h0;
        csrm[CSR_MTVEC] = 64'h8000_3000;
        exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 64'h100; exc_tval = 64'h7;
        step();
        idle_in();
        step();
        #2;
        check_eq("tcause_valid", csr_valid, 1'b1);
        check_eq("tcause_wa", csr_wa, 64'(CSR_MCAUSE));
        reset = 1'b0;
        #1;
        check_eq("midrst_csr_valid", csr_valid, 1'b0);
        check_eq("midrst_redir", redirect_valid, 1'b0);
        check_eq("midrst_stall", stall, 1'b0);
        check_eq("midrst_wb_ready", wb_csr_ready, 1'b0);
        sched.delete();
        for (int unsigned i = 0; i < 3; i++) begin
            @(posedge clk);
            #3;
            check_eq("inrst_csr_valid", csr_valid, 1'b0);
            check_eq("inrst_redir", redirect_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        obs_w.delete();
        exc_valid = 1'b1; exc_code = 5'd6; exc_pc = 64'h2000; exc_tval = 64'h9;
        step();
        idle_in();
        repeat (6) step();
        check_eq("postrst_mcause", obs_w[CSR_MCAUSE], 64'd6);
        check_eq("postrst_redir_pc", last_redir, 64'h8000_3000);

        // Random traffic
        for (int unsigned i = 0; i < 400; i++) begin
            exc_valid    = ($urandom_range(0, 5) == 0);
            mret_valid   = ($urandom_range(0, 5) == 0);
            exc_code     = 5'($urandom_range(0, 31));
            exc_pc       = {$urandom, $urandom};
            exc_tval     = {$urandom, $urandom};
            wb_csr_valid = ($urandom_range(0, 1) == 1);
            wb_csr_wa    = addrs[$urandom_range(0, 6)];
            wb_csr_wd    = {$urandom, $urandom};
            step();
        end
        idle_in();
        repeat (8) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
